// File: rtl/noc_hdr_route_stage.sv
// noc_hdr_route_stage: header decode, dimension-order route, nxt_jump rewrite, skid-buffered forward and per-port counters
module noc_hdr_route_stage #(
  parameter int PCK_SZ = 40,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int MY_ROW = 0,
  parameter int MY_COL = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PCK_SZ-1:0] in_pkt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PCK_SZ-1:0] out_pkt,
  output logic [2:0]        out_port,
  output logic              drop_pulse,
  input  logic [2:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_val,
  input  logic              cnt_clr
);
  localparam logic [3:0] ROW = 4'(MY_ROW);
  localparam logic [3:0] COL = 4'(MY_COL);
  logic [3:0] trgt_r, trgt_c;
  logic mode, accept, drop, fwd, depart;
  logic [2:0] row_port, col_port, rt_port;
  logic [PCK_SZ-1:0] rt_pkt;
  logic skid_valid;
  logic [PCK_SZ-1:0] skid_pkt;
  logic [2:0] skid_port;
  logic [5:0] inc;
  logic [CNT_W-1:0] cnt [0:5];
  assign trgt_r = in_pkt[PCK_SZ-9:PCK_SZ-12];
  assign trgt_c = in_pkt[PCK_SZ-13:PCK_SZ-16];
  assign mode = in_pkt[PCK_SZ-17];
  assign row_port = trgt_r < ROW ? 3'd1 : trgt_r > ROW ? 3'd2 : 3'd0;
  assign col_port = trgt_c < COL ? 3'd3 : trgt_c > COL ? 3'd4 : 3'd0;
  assign rt_port = mode ? (row_port != 3'd0 ? row_port : col_port)
                        : (col_port != 3'd0 ? col_port : row_port);
  assign rt_pkt = {5'b0, rt_port, in_pkt[PCK_SZ-9:0]};
  assign in_ready = !skid_valid;
  assign accept = in_valid && in_ready;
  assign drop = accept && ({1'b0, trgt_r} >= 5'(N_ROWS) || {1'b0, trgt_c} >= 5'(N_COLS));
  assign fwd = accept && !drop;
  assign depart = out_valid && out_ready;
  assign inc = {drop, depart ? 5'(1) << out_port : 5'd0};
  assign cnt_val = cnt_sel < 3'd6 ? cnt[cnt_sel] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pkt    <= '0;
      out_port   <= '0;
      skid_valid <= 1'b0;
      skid_pkt   <= '0;
      skid_port  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (!out_valid || out_ready) begin
        out_valid  <= skid_valid || fwd;
        out_pkt    <= skid_valid ? skid_pkt : fwd ? rt_pkt : out_pkt;
        out_port   <= skid_valid ? skid_port : fwd ? rt_port : out_port;
        skid_valid <= 1'b0;
      end else if (fwd) begin
        skid_valid <= 1'b1;
        skid_pkt   <= rt_pkt;
        skid_port  <= rt_port;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++)
        cnt[i] <= cnt_clr ? '0 : (inc[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
    end
  end
endmodule

// File: tb/tb_noc_hdr_route_stage.sv
// tb_noc_hdr_route_stage: directed vectors and hand-written sequences for the route stage at node (1,1)
module tb_noc_hdr_route_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic in_ready, out_valid, drop_pulse;
  logic [39:0] in_pkt = '0, out_pkt;
  logic [2:0] out_port, cnt_sel = '0;
  logic [1:0] cnt_val;
  int checks = 0, failures = 0;
  typedef struct {logic mode; logic [3:0] r; logic [3:0] c; logic [2:0] port;} vec_t;
  vec_t vecs [8];
  logic [39:0] s [4];
  logic [39:0] p;
  logic [2:0] exp_cnt [5];

  noc_hdr_route_stage #(.PCK_SZ(40), .N_ROWS(4), .N_COLS(4), .MY_ROW(1), .MY_COL(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt), .out_port(out_port),
    .drop_pulse(drop_pulse), .cnt_sel(cnt_sel), .cnt_val(cnt_val), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mk(input logic m, input logic [3:0] r, input logic [3:0] c, input logic [22:0] pl);
    return {8'hA5, r, c, m, pl};
  endfunction

  function automatic logic [39:0] rw(input logic [39:0] pk, input logic [2:0] port);
    return {5'b0, port, pk[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_cnt(input string name, input logic [2:0] sel, input logic [1:0] exp);
    cnt_sel = sel;
    #1;
    chk(name, 64'(cnt_val), 64'(exp));
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd3, 4'd0, 3'd2};
    vecs[1] = '{1'b0, 4'd3, 4'd0, 3'd3};
    vecs[2] = '{1'b1, 4'd1, 4'd1, 3'd0};
    vecs[3] = '{1'b1, 4'd0, 4'd3, 3'd1};
    vecs[4] = '{1'b0, 4'd0, 4'd3, 3'd4};
    vecs[5] = '{1'b0, 4'd1, 4'd1, 3'd0};
    vecs[6] = '{1'b1, 4'd1, 4'd2, 3'd4};
    vecs[7] = '{1'b0, 4'd2, 4'd1, 3'd2};
    exp_cnt = '{3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pkt", 64'(out_pkt), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_drop", 64'(drop_pulse), 64'd0);
    for (int i = 0; i < 6; i++) rd_cnt("rst_cnt", 3'(i), 2'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = mk(vecs[i].mode, vecs[i].r, vecs[i].c, 23'(i * 12345 + 7));
      in_valid = 1'b1;
      in_pkt = p;
      tick;
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_port", 64'(out_port), 64'(vecs[i].port));
      chk("vec_pkt", 64'(out_pkt), 64'(rw(p, vecs[i].port)));
      in_valid = 1'b0;
    end
    tick;
    chk("vec_drained", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) rd_cnt("port_cnt", 3'(i), 2'(exp_cnt[i]));
    rd_cnt("drop_cnt0", 3'd5, 2'd0);
    rd_cnt("cnt_sel6", 3'd6, 2'd0);

    s[0] = mk(1'b1, 4'd0, 4'd1, 23'h11111);
    s[1] = mk(1'b1, 4'd2, 4'd1, 23'h22222);
    s[2] = mk(1'b0, 4'd1, 4'd0, 23'h33333);
    s[3] = mk(1'b0, 4'd1, 4'd3, 23'h44444);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pkt = s[0];
    tick;
    chk("stall_p0", 64'(out_pkt), 64'(rw(s[0], 3'd1)));
    chk("stall_rdy1", 64'(in_ready), 64'd1);
    in_pkt = s[1];
    tick;
    chk("stall_rdy0a", 64'(in_ready), 64'd0);
    chk("stall_hold_a", 64'(out_pkt), 64'(rw(s[0], 3'd1)));
    in_pkt = s[2];
    tick;
    chk("stall_rdy0b", 64'(in_ready), 64'd0);
    chk("stall_hold_b", 64'(out_pkt), 64'(rw(s[0], 3'd1)));
    chk("stall_hold_port", 64'(out_port), 64'd1);
    out_ready = 1'b1;
    tick;
    chk("rel_p1", 64'(out_pkt), 64'(rw(s[1], 3'd2)));
    chk("rel_rdy", 64'(in_ready), 64'd1);
    tick;
    chk("rel_p2", 64'(out_pkt), 64'(rw(s[2], 3'd3)));
    in_pkt = s[3];
    tick;
    chk("rel_p3", 64'(out_pkt), 64'(rw(s[3], 3'd4)));
    in_valid = 1'b0;
    tick;
    chk("rel_empty", 64'(out_valid), 64'd0);

    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    in_valid = 1'b1;
    in_pkt = mk(1'b1, 4'd5, 4'd0, 23'h5);
    tick;
    chk("drop_pulse", 64'(drop_pulse), 64'd1);
    chk("drop_noval", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    tick;
    chk("drop_once", 64'(drop_pulse), 64'd0);
    chk("drop_noval2", 64'(out_valid), 64'd0);
    rd_cnt("drop_cnt1", 3'd5, 2'd1);
    in_valid = 1'b1;
    in_pkt = mk(1'b0, 4'd0, 4'd9, 23'h6);
    tick;
    chk("b2b_pulse1", 64'(drop_pulse), 64'd1);
    chk("b2b_rdy", 64'(in_ready), 64'd1);
    in_pkt = mk(1'b1, 4'd2, 4'd4, 23'h7);
    tick;
    chk("b2b_pulse2", 64'(drop_pulse), 64'd1);
    p = mk(1'b1, 4'd3, 4'd3, 23'h8);
    in_pkt = p;
    tick;
    chk("after_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("after_drop_valid", 64'(out_valid), 64'd1);
    chk("after_drop_pkt", 64'(out_pkt), 64'(rw(p, 3'd2)));
    in_valid = 1'b0;
    tick;
    rd_cnt("drop_cnt3", 3'd5, 2'd3);

    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    in_valid = 1'b1;
    in_pkt = mk(1'b0, 4'd1, 4'd2, 23'h9);
    repeat (5) tick;
    in_valid = 1'b0;
    tick;
    rd_cnt("east_sat", 3'd4, 2'd3);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    rd_cnt("clr_priority", 3'd4, 2'd0);
    chk("clr_drained", 64'(out_valid), 64'd0);

    in_valid = 1'b1;
    in_pkt = mk(1'b1, 4'd0, 4'd1, 23'hA);
    tick;
    in_valid = 1'b0;
    tick;
    rd_cnt("north_cnt", 3'd1, 2'd1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick;
    in_pkt = mk(1'b1, 4'd2, 4'd1, 23'hB);
    tick;
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_rdy", 64'(in_ready), 64'd1);
    chk("async_drop", 64'(drop_pulse), 64'd0);
    rd_cnt("async_cnt", 3'd1, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("post_rst_rdy", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_pkt", 64'(out_pkt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
